rr_arbiter_n: RTL and testbench

Parametrised N-way round-robin arbiter with bounded grant hold (burst lock) and a registered one-hot grant. It is the generalised successor of the 2-requester round-robin arbiter. It sits in front of any shared resource in the accelerator, such as a memory port, bus master or PE result writeback, where several agents contend. A holder keeps the resource while it keeps requesting, up to MAX_HOLD cycles. Priority then rotates so that no requester starves.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 27 ++
 rtl/rr_arbiter_n.sv | 76 +++++++
 tb/tb_rr_arbiter_n.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin arbiter family
package arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] onehot(input logic [4:0] i);
        return 32'd1 << i;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr with wrap-around
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;

    // Masked copy in the low half takes priority; unmasked copy in the high half supplies the wrap
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) w_mask[i] = (i >= int'(ptr));
        w_dbl = {req, req & w_mask};
        idx   = '0;
        for (int i = 2*N-1; i >= 0; i--) if (w_dbl[i]) idx = IDX_W'((i >= N) ? i - N : i);
        found = |req;
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter with bounded grant hold and registered one-hot grant
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IDX_W    = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    localparam int                HOLD_W    = idx_w(MAX_HOLD);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(MAX_HOLD - 1);

    state_t              r_state, w_next;
    logic [IDX_W-1:0]    r_ptr, r_idx, w_idx;
    logic [HOLD_W-1:0]   r_hold;
    logic [N-1:0]        r_grant;
    logic                r_vld, w_found, w_keep;
    logic [31:0]         w_oh;

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .idx   (w_idx),
        .found (w_found)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and hold decision: holder keeps the grant until its hold window is spent
    always_comb begin
        w_next = IDLE;
        w_keep = 1'b0;
        w_oh   = onehot(5'(w_idx));
        w_keep = (r_state == GRANT) && req[r_idx] && (r_hold < LAST_HOLD);
        w_next = w_found ? GRANT : IDLE;
    end

    // Grant, pointer and hold counter registers; idle keeps the last index and the pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else if (w_keep) begin
            r_hold  <= r_hold + 1'b1;
        end else if (w_found) begin
            r_grant <= w_oh[N-1:0];
            r_idx   <= w_idx;
            r_vld   <= 1'b1;
            r_ptr   <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
            r_hold  <= '0;
        end else begin
            r_grant <= '0;
            r_vld   <= 1'b0;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign grant_vld = r_vld;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: table-driven scoreboard bench for rr_arbiter_n (N=4/MH=4, N=3/MH=1, N=5/MH=4)
module tb_rr_arbiter_n;

    typedef struct {
        logic       rst_n;
        int         dut;
        logic [4:0] req;
        logic [4:0] grant;
        logic [2:0] idx;
        logic       vld;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req4 = '0;
    logic [2:0] req3 = '0;
    logic [4:0] req5 = '0;
    logic [3:0] g4;
    logic [2:0] g3;
    logic [4:0] g5;
    logic [1:0] i4, i3;
    logic [2:0] i5;
    logic       v4, v3, v5;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .req(req4), .grant(g4), .grant_idx(i4), .grant_vld(v4));
    rr_arbiter_n #(.N(3), .MAX_HOLD(1)) dut3 (.clk(clk), .rst_n(rst_n), .req(req3), .grant(g3), .grant_idx(i3), .grant_vld(v3));
    rr_arbiter_n #(.N(5), .MAX_HOLD(4)) dut5 (.clk(clk), .rst_n(rst_n), .req(req5), .grant(g5), .grant_idx(i5), .grant_vld(v5));

    task automatic add(input logic r, input int d, input logic [4:0] rq, input logic [4:0] g,
                       input logic [2:0] ix, input logic v, input int n);
        vec_t e;
        e = '{rst_n: r, dut: d, req: rq, grant: g, idx: ix, vld: v};
        repeat (n) tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        logic [4:0] ag;
        logic [2:0] ai;
        logic       av;
        int         waited;
        // reset with all requesting, then full contention on N=4
        add(0, 0, 5'h0F, 5'h00, 0, 0, 3);
        add(1, 0, 5'h0F, 5'h01, 0, 1, 4);
        add(1, 0, 5'h0F, 5'h02, 1, 1, 4);
        add(1, 0, 5'h0F, 5'h04, 2, 1, 4);
        add(1, 0, 5'h0F, 5'h08, 3, 1, 4);
        add(1, 0, 5'h0F, 5'h01, 0, 1, 1);
        add(1, 0, 5'h00, 5'h00, 0, 0, 1);
        // early release and idle with held index
        add(0, 0, 5'h00, 5'h00, 0, 0, 1);
        add(1, 0, 5'h05, 5'h01, 0, 1, 2);
        add(1, 0, 5'h04, 5'h04, 2, 1, 2);
        add(1, 0, 5'h00, 5'h00, 2, 0, 1);
        add(1, 0, 5'h01, 5'h01, 0, 1, 1);
        // lone holder re-arms, then a second requester waits out the window
        add(1, 0, 5'h02, 5'h02, 1, 1, 10);
        add(1, 0, 5'h03, 5'h02, 1, 1, 2);
        add(1, 0, 5'h03, 5'h01, 0, 1, 1);
        // reset mid-grant clears ptr
        add(1, 0, 5'h04, 5'h04, 2, 1, 1);
        add(0, 0, 5'h04, 5'h00, 0, 0, 1);
        add(1, 0, 5'h0C, 5'h04, 2, 1, 4);
        add(1, 0, 5'h0C, 5'h08, 3, 1, 1);
        // N=3, MAX_HOLD=1 rotates every cycle
        add(0, 1, 5'h00, 5'h00, 0, 0, 1);
        add(1, 1, 5'h07, 5'h01, 0, 1, 1);
        add(1, 1, 5'h07, 5'h02, 1, 1, 1);
        add(1, 1, 5'h07, 5'h04, 2, 1, 1);
        add(1, 1, 5'h07, 5'h01, 0, 1, 1);
        // N=5 pointer wraps from 4 back to 0
        add(0, 2, 5'h00, 5'h00, 0, 0, 1);
        add(1, 2, 5'h11, 5'h01, 0, 1, 4);
        add(1, 2, 5'h11, 5'h10, 4, 1, 4);
        add(1, 2, 5'h11, 5'h01, 0, 1, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst_n = tbl[k].rst_n;
            req4  = (tbl[k].dut == 0) ? tbl[k].req[3:0] : 4'h0;
            req3  = (tbl[k].dut == 1) ? tbl[k].req[2:0] : 3'h0;
            req5  = (tbl[k].dut == 2) ? tbl[k].req : 5'h0;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            e  = sb.pop_front();
            ag = (e.dut == 0) ? {1'b0, g4} : (e.dut == 1) ? {2'b0, g3} : g5;
            ai = (e.dut == 0) ? {1'b0, i4} : (e.dut == 1) ? {1'b0, i3} : i5;
            av = (e.dut == 0) ? v4 : (e.dut == 1) ? v3 : v5;
            checks++;
            if ({ag, ai, av} !== {e.grant, e.idx, e.vld}) begin
                errors++;
                $display("FAIL vec%0d dut%0d: grant=%b idx=%0d vld=%b, expected grant=%b idx=%0d vld=%b",
                         k, e.dut, ag, ai, av, e.grant, e.idx, e.vld);
            end
        end

        // single late requester from idle, bounded wait for the grant
        @(negedge clk);
        req3 = '0;
        req5 = '0;
        req4 = 4'b1000;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!v4 && waited < 4);
        chk("late_req_latency", 8'(waited), 8'd1);
        chk("late_req_grant", {4'h0, g4}, 8'h08);
        chk("late_req_idx", {6'h0, i4}, 8'd3);
        @(negedge clk);
        req4 = 4'b0000;
        @(posedge clk);
        #1;
        chk("drop_grant", {3'h0, v4, g4}, 8'h00);
        chk("drop_idx_held", {6'h0, i4}, 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
